// File: rtl/irq_ctrl_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// irq_ctrl_if
// CPU valid/ready slave bus that carries register accesses to irq_ctrl.
//   valid  master -> slave  request, already qualified by address select
//   ready  slave -> master  one-cycle acknowledge
//   wstrb  master -> slave  byte write strobes, 4'b0000 = read
//   addr   master -> slave  byte address
//   wdata  master -> slave  write data
//   rdata  slave -> master  read data, valid while ready = 1, else 0
// ----------------------------------------------------------------------------
interface irq_ctrl_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output valid, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, wstrb, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/irq_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// irq_ctrl
// Memory-mapped interrupt controller. Synchronises NUM_CH asynchronous
// interrupt inputs and applies per-channel level/edge mode, polarity,
// both-edge detection, enable masking and a pending register with
// write-1-to-clear and software set.
//
// Ports
//   clk     system clock
//   reset   synchronous, active-high reset
//   bus     irq_ctrl_if slave: valid/ready register access, addr[4:2] decoded
//   irq_in  asynchronous interrupt sources
//   irq     registered pending & enable, to the CPU irq vector
//
// Register map (addr[4:2])
//   0 RAW      RO   synchronised input levels
//   1 ENABLE   RW
//   2 MODE     RW   1 = edge, 0 = level
//   3 POL      RW   1 = rising/high, 0 = falling/low
//   4 PENDING  R/W1C (edge channels only)
//   5 SOFTSET  WO   set pending on edge channels, reads 0
//   6 BOTH     RW   edge channels trigger on either edge
//   7 reserved      reads 0, writes ignored, still acknowledged
// Bits at or above NUM_CH read 0 and ignore writes.
// ----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    irq_ctrl_if.slave         bus,
    input  logic [NUM_CH-1:0] irq_in,
    output logic [NUM_CH-1:0] irq
);

    typedef enum logic [2:0] {
        REG_RAW     = 3'd0,
        REG_ENABLE  = 3'd1,
        REG_MODE    = 3'd2,
        REG_POL     = 3'd3,
        REG_PENDING = 3'd4,
        REG_SOFTSET = 3'd5,
        REG_BOTH    = 3'd6,
        REG_RSVD    = 3'd7
    } reg_sel_e;

    // Warm-up covers the synchroniser fill plus the s_d stage, so the
    // reset-to-live transition of the chain is never seen as an edge.
    localparam int              WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

    // Zero-extend a channel vector to the 32-bit bus width.
    function automatic logic [31:0] zext(input logic [NUM_CH-1:0] v);
        logic [31:0] r;
        r            = '0;
        r[NUM_CH-1:0] = v;
        return r;
    endfunction

    // Byte-strobed update of a channel register; bits >= NUM_CH drop out.
    function automatic logic [NUM_CH-1:0] merge(input logic [NUM_CH-1:0] old_v,
                                                input logic [31:0]       bmask,
                                                input logic [31:0]       wbits);
        logic [31:0] r;
        r = (zext(old_v) & ~bmask) | wbits;
        return r[NUM_CH-1:0];
    endfunction

    // State
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]  s_d;
    logic [WARM_W-1:0]  warm_q;
    logic [NUM_CH-1:0]  enable_q, mode_q, pol_q, both_q, pending_q;
    logic               ready_q;
    logic [31:0]        rdata_q;

    // Combinational
    reg_sel_e           sel;
    logic               ack, wr;
    logic [31:0]        bmask, wbits, rd_val;
    logic [NUM_CH-1:0]  s, edge_raw, edge_det, clr, set;
    logic [NUM_CH-1:0]  enable_nxt, mode_nxt, pol_nxt, both_nxt, mode_chg;
    logic [NUM_CH-1:0]  pend_edge, pend_lvl, pending_nxt;
    logic               unused_addr;

    assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};
    assign s           = sync_q[SYNC_STAGES-1];
    assign bus.ready   = ready_q;
    assign bus.rdata   = rdata_q;

    // NOTE: every signal driven here gets a default before any condition so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        sel    = reg_sel_e'(bus.addr[4:2]);
        // Accept only when not already acknowledging: blocks a double ack.
        ack    = bus.valid && !ready_q;
        wr     = ack && (bus.wstrb != 4'b0000);
        bmask  = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}},
                  {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
        wbits  = bus.wdata & bmask;

        enable_nxt = enable_q;
        mode_nxt   = mode_q;
        pol_nxt    = pol_q;
        both_nxt   = both_q;
        clr        = '0;
        set        = '0;
        if (wr) begin
            case (sel)
                REG_ENABLE:  enable_nxt = merge(enable_q, bmask, wbits);
                REG_MODE:    mode_nxt   = merge(mode_q,   bmask, wbits);
                REG_POL:     pol_nxt    = merge(pol_q,    bmask, wbits);
                REG_BOTH:    both_nxt   = merge(both_q,   bmask, wbits);
                REG_PENDING: clr        = wbits[NUM_CH-1:0];
                REG_SOFTSET: set        = wbits[NUM_CH-1:0];
                default:     ;
            endcase
        end
        mode_chg = mode_q ^ mode_nxt;

        edge_raw = (both_q & (s ^ s_d))
                 | (~both_q &  pol_q &  s & ~s_d)
                 | (~both_q & ~pol_q & ~s &  s_d);
        edge_det = (warm_q == '0) ? edge_raw : '0;

        // Edge channels: set (edge or softset) wins over a same-cycle clear.
        pend_edge   = (pending_q & ~clr) | edge_det | set;
        pend_lvl    = ~(s ^ pol_q);
        // A mode switch discards the stale pending state of that channel.
        pending_nxt = ((mode_q & pend_edge) | (~mode_q & pend_lvl)) & ~mode_chg;

        rd_val = '0;
        case (sel)
            REG_RAW:     rd_val = zext(s);
            REG_ENABLE:  rd_val = zext(enable_q);
            REG_MODE:    rd_val = zext(mode_q);
            REG_POL:     rd_val = zext(pol_q);
            REG_PENDING: rd_val = zext(pending_q);
            REG_BOTH:    rd_val = zext(both_q);
            default:     rd_val = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values (e.g. rdata sees the value before the write).
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            sync_q    <= '0;
            s_d       <= '0;
            warm_q    <= WARM_INIT;
            enable_q  <= '0;
            mode_q    <= '0;
            pol_q     <= '0;
            both_q    <= '0;
            pending_q <= '0;
            irq       <= '0;
        end else begin
            ready_q   <= ack;
            rdata_q   <= ack ? rd_val : 32'h0;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
            s_d       <= s;
            if (warm_q != '0) begin
                warm_q <= warm_q - WARM_W'(1);
            end
            enable_q  <= enable_nxt;
            mode_q    <= mode_nxt;
            pol_q     <= pol_nxt;
            both_q    <= both_nxt;
            pending_q <= pending_nxt;
            irq       <= pending_q & enable_q;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_irq_ctrl
// Directed bench for irq_ctrl (NUM_CH = 8, SYNC_STAGES = 3). Stimulus pushes
// expected bus read data and expected irq values (tagged with the cycle they
// must appear) into queues; a monitor on the falling edge pops and compares.
// With a 3-stage synchroniser, an input driven just after edge c reaches
// pending at edge c+4 and irq at edge c+5.
// ----------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam int NUM_CH = 8;
    localparam int SYNC   = 3;
    localparam int LAT    = SYNC + 2;

    localparam logic [2:0] A_RAW = 3'd0, A_EN = 3'd1, A_MODE = 3'd2, A_POL = 3'd3,
                           A_PEND = 3'd4, A_SOFT = 3'd5, A_BOTH = 3'd6, A_RSVD = 3'd7;

    typedef struct {
        string       name;
        logic        is_read;
        logic [31:0] data;
    } bus_exp_t;

    typedef struct {
        string       name;
        int          cyc;
        logic [7:0]  mask;
        logic [7:0]  val;
    } irq_exp_t;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic [NUM_CH-1:0] irq_in = '0;
    logic [NUM_CH-1:0] irq;
    int                cyc    = 0;
    int                n_checks = 0;
    int                n_fail   = 0;
    bus_exp_t          bus_q[$];
    irq_exp_t          irq_q[$];

    irq_ctrl_if bus ();

    irq_ctrl #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .irq_in (irq_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_irq(input string name, input int at, input logic [7:0] mask,
                            input logic [7:0] val);
        irq_exp_t e;
        e.name = name; e.cyc = at; e.mask = mask; e.val = val;
        irq_q.push_back(e);
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.ready !== 1'b1 && n < 16);
        if (bus.ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: ready=%b after %0d cycles, expected 1", name, bus.ready, n);
            bus_q.delete(bus_q.size() - 1);
        end
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
    endtask

    task automatic bus_xfer(input string name, input logic [2:0] off, input logic [3:0] strb,
                            input logic [31:0] wd, input logic is_read, input logic [31:0] exp);
        bus_exp_t e;
        e.name = name; e.is_read = is_read; e.data = exp;
        bus_q.push_back(e);
        bus.addr  = {27'd0, off, 2'b00};
        bus.wstrb = strb;
        bus.wdata = wd;
        bus.valid = 1'b1;
        wait_ack(name);
    endtask

    task automatic wr(input string name, input logic [2:0] off, input logic [3:0] strb,
                      input logic [31:0] wd);
        bus_xfer(name, off, strb, wd, 1'b0, 32'h0);
    endtask

    task automatic rd(input string name, input logic [2:0] off, input logic [31:0] exp);
        bus_xfer(name, off, 4'h0, 32'h0, 1'b1, exp);
    endtask

    // Monitor: every ack must match the oldest outstanding request; irq is
    // compared on the cycle each expectation names.
    always @(negedge clk) begin
        bus_exp_t be;
        irq_exp_t ie;
        if (bus.ready === 1'b1) begin
            if (bus_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: ready=1 with no request outstanding (cycle %0d)", cyc);
            end else begin
                be = bus_q.pop_front();
                if (be.is_read) check(be.name, bus.rdata, be.data);
            end
        end
        while (irq_q.size() != 0 && irq_q[0].cyc <= cyc) begin
            ie = irq_q.pop_front();
            if (ie.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_missed: expectation for cycle %0d not sampled", ie.name, ie.cyc);
            end else begin
                check(ie.name, {24'd0, irq & ie.mask}, {24'd0, ie.val & ie.mask});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int a;
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;

        // T1 reset: outputs quiet, registers clear. All channels come up in
        // level/active-low mode with inputs low, so PENDING reads all ones.
        tick(3);
        check("reset_ready", {31'd0, bus.ready}, 32'h0);
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_irq",   {24'd0, irq}, 32'h0);
        reset = 1'b0;
        tick(SYNC + 2);
        rd("t1_raw",    A_RAW,  32'h0);
        rd("t1_enable", A_EN,   32'h0);
        rd("t1_mode",   A_MODE, 32'h0);
        rd("t1_pol",    A_POL,  32'h0);
        rd("t1_pend",   A_PEND, 32'h0000_00FF);
        rd("t1_soft",   A_SOFT, 32'h0);
        rd("t1_both",   A_BOTH, 32'h0);
        rd("t1_rsvd",   A_RSVD, 32'h0);

        // T2 rising edge on ch3, one-cycle pulse, then W1C.
        wr("t2_mode", A_MODE, 4'hF, 32'h08);
        wr("t2_pol",  A_POL,  4'hF, 32'h08);
        wr("t2_en",   A_EN,   4'hF, 32'h08);
        tick(2);
        c = cyc;
        push_irq("t2_irq_before", c + LAT - 1, 8'h08, 8'h00);
        push_irq("t2_irq_rise",   c + LAT,     8'h08, 8'h08);
        push_irq("t2_irq_hold1",  c + LAT + 1, 8'h08, 8'h08);
        push_irq("t2_irq_hold3",  c + LAT + 3, 8'h08, 8'h08);
        irq_in[3] = 1'b1;
        tick(1);
        irq_in[3] = 1'b0;
        tick(LAT + 4);
        rd("t2_pend_set", A_PEND, 32'h0000_00FF);
        tick(2);
        a = cyc + 1;
        push_irq("t2_irq_at_clr", a,     8'h08, 8'h08);
        push_irq("t2_irq_cleared", a + 1, 8'h08, 8'h00);
        wr("t2_w1c", A_PEND, 4'hF, 32'h08);
        tick(2);
        rd("t2_pend_clr", A_PEND, 32'h0000_00F7);

        // T3 level-low on ch0.
        wr("t3_mode", A_MODE, 4'hF, 32'h00);
        wr("t3_pol",  A_POL,  4'hF, 32'h00);
        wr("t3_en",   A_EN,   4'hF, 32'h01);
        tick(2);
        push_irq("t3_irq_level", cyc + 1, 8'hFF, 8'h01);
        wr("t3_w1c", A_PEND, 4'hF, 32'h01);
        rd("t3_pend_w1c_ignored", A_PEND, 32'h0000_00FF);
        tick(2);
        c = cyc;
        push_irq("t3_irq_still", c + LAT - 1, 8'h01, 8'h01);
        push_irq("t3_irq_drop",  c + LAT,     8'h01, 8'h00);
        irq_in[0] = 1'b1;
        tick(LAT + 2);
        rd("t3_pend_inactive", A_PEND, 32'h0000_00FE);
        irq_in[0] = 1'b0;
        tick(LAT + 1);

        // T4 set/clear collision on ch2 (rising), then both-edge on ch1.
        wr("t4_pol",  A_POL,  4'hF, 32'h04);
        wr("t4_mode", A_MODE, 4'hF, 32'h06);
        wr("t4_both", A_BOTH, 4'hF, 32'h02);
        wr("t4_en",   A_EN,   4'hF, 32'h00);
        tick(2);
        rd("t4_pend_init", A_PEND, 32'h0000_00F9);
        tick(2);
        irq_in[2] = 1'b1;
        tick(SYNC);
        wr("t4_w1c_collide", A_PEND, 4'hF, 32'h04);
        rd("t4_pend_set_wins", A_PEND, 32'h0000_00FD);
        tick(2);
        irq_in[1] = 1'b1;
        tick(LAT);
        rd("t4_both_rise", A_PEND, 32'h0000_00FF);
        wr("t4_w1c_ch1", A_PEND, 4'hF, 32'h02);
        rd("t4_both_cleared", A_PEND, 32'h0000_00FD);
        tick(2);
        irq_in[1] = 1'b0;
        tick(LAT);
        rd("t4_both_fall", A_PEND, 32'h0000_00FF);
        wr("t4_w1c_ch12", A_PEND, 4'hF, 32'h06);
        tick(2);
        irq_in[2] = 1'b0;
        tick(LAT);
        rd("t4_rise_only_no_fall", A_PEND, 32'h0000_00F9);

        // T5 byte strobes, softset, reserved, raw.
        wr("t5_en_byte0", A_EN, 4'b0001, 32'hFFFF_FFFF);
        rd("t5_en_byte0", A_EN, 32'h0000_00FF);
        wr("t5_en_byte1", A_EN, 4'b0010, 32'h0000_0000);
        rd("t5_en_byte1", A_EN, 32'h0000_00FF);
        wr("t5_softset", A_SOFT, 4'hF, 32'h04);
        rd("t5_pend_soft", A_PEND, 32'h0000_00FD);
        rd("t5_soft_read", A_SOFT, 32'h0);
        wr("t5_mode_wide", A_MODE, 4'hF, 32'hFFFF_FF06);
        rd("t5_mode_wide", A_MODE, 32'h0000_0006);
        wr("t5_rsvd_wr", A_RSVD, 4'hF, 32'hFFFF_FFFF);
        rd("t5_rsvd_rd", A_RSVD, 32'h0);
        irq_in = 8'hA5;
        tick(SYNC + 1);
        rd("t5_raw", A_RAW, 32'h0000_00A5);

        // T6 warm-up: ch1 held high through reset and configured rising edge
        // before the warm-up counter expires; no pending may result.
        tick(2);
        irq_in = 8'h02;
        reset  = 1'b1;
        tick(3);
        reset  = 1'b0;
        wr("t6_mode", A_MODE, 4'hF, 32'h02);
        wr("t6_pol",  A_POL,  4'hF, 32'h02);
        tick(SYNC + 3);
        push_irq("t6_irq_off", cyc + 1, 8'hFF, 8'h00);
        rd("t6_pend_warm", A_PEND, 32'h0000_00FD);
        rd("t6_raw", A_RAW, 32'h0000_0002);

        // T6 reset while a request is held: no ack during reset, then a
        // normal ack of the still-held request with reset register values.
        wr("t6_en_set", A_EN, 4'hF, 32'h5A);
        tick(2);
        bus.addr  = {27'd0, A_EN, 2'b00};
        bus.wstrb = 4'h0;
        bus.wdata = 32'h0;
        bus.valid = 1'b1;
        reset     = 1'b1;
        tick(2);
        begin
            bus_exp_t e;
            e.name = "t6_en_after_reset"; e.is_read = 1'b1; e.data = 32'h0;
            bus_q.push_back(e);
        end
        reset = 1'b0;
        wait_ack("t6_held_req");
        rd("t6_mode_after_reset", A_MODE, 32'h0);

        tick(LAT + 4);
        check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
        check("irq_queue_drained", 32'(irq_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
